// File: rtl/pal_cfg_pkg.sv
// Shared types and constants for the PAL configuration loader.
// The CRC helper is used only when PAL_CFG_CRC_EN is defined.
package pal_cfg_pkg;

  localparam int         BYTE_W    = 8;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } pal_state_e;

  // One MSB-first CRC-8 step for a single serial bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/pal_cfg_if.sv
// Host byte handshake plus PAL serial config signals of the loader.
interface pal_cfg_if;

  logic                            start;
  logic [pal_cfg_pkg::BYTE_W-1:0]  din;
  logic                            din_valid;
  logic                            din_ready;
  logic                            cfg_out;
  logic                            cfg_en;
  logic                            busy;
  logic                            done;
  logic                            err;

  modport master (
    output start, din, din_valid,
    input  din_ready, cfg_out, cfg_en, busy, done, err
  );

  modport slave (
    input  start, din, din_valid,
    output din_ready, cfg_out, cfg_en, busy, done, err
  );

endinterface

// File: rtl/pal_cfg_crc8.sv
// Bit-serial CRC-8 (MSB-first) over the config bits driven to the PAL.
// Instantiated by the loader only when PAL_CFG_CRC_EN is defined.
module pal_cfg_crc8
  import pal_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       din,
  output logic [7:0] crc
);

  logic [7:0] crc_r;

  // CRC register: clear wins over update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_r <= CRC8_INIT;
    end else if (clr) begin
      crc_r <= CRC8_INIT;
    end else if (en) begin
      crc_r <= crc8_step(crc_r, din);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/pal_cfg_loader.sv
// PAL configuration sequencer: bytes in over valid/ready, MSB-first serial out to the PAL.
// Optional CRC-8 check of the delivered bitstream is enabled by defining PAL_CFG_CRC_EN.
module pal_cfg_loader
  import pal_cfg_pkg::*;
#(
  parameter int CFG_BITS = 192
) (
  input  logic     clk,
  input  logic     rst,
  pal_cfg_if.slave bus
);

  localparam int               CNT_W    = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CFG_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CFG_BITS);

  pal_state_e        state_r, state_nxt_s;
  logic [BYTE_W-1:0] shreg_r, shreg_nxt_s;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic              cfg_en_r, cfg_en_nxt_s;
  logic              cfg_out_r, cfg_out_nxt_s;
  logic              busy_r, done_r;
  logic              din_ready_s, hs_s, start_ok_s, last_bit_s, byte_end_s;

  assign din_ready_s = (state_r == ST_LOAD) || (state_r == ST_CHECK);
  assign hs_s        = bus.din_valid && din_ready_s;
  assign start_ok_s  = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  // bit_cnt indexes the bit currently on cfg_out while in SHIFT
  assign last_bit_s  = (bit_cnt_r == LAST_IDX);
  assign byte_end_s  = (bit_cnt_r[2:0] == 3'd7);

  // Next-state, shift register and next registered-output decode
  always_comb begin
    state_nxt_s   = state_r;
    shreg_nxt_s   = shreg_r;
    cfg_en_nxt_s  = 1'b0;
    cfg_out_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (hs_s) begin
          state_nxt_s   = ST_SHIFT;
          cfg_en_nxt_s  = 1'b1;
          cfg_out_nxt_s = bus.din[BYTE_W-1];
          shreg_nxt_s   = {bus.din[BYTE_W-2:0], 1'b0};
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_SHIFT: begin
        if (last_bit_s) begin
`ifdef PAL_CFG_CRC_EN
          state_nxt_s = ST_CHECK;
`else
          state_nxt_s = ST_DONE;
`endif
          // unused LSBs of a partial final byte are dropped here
          shreg_nxt_s = '0;
        end else if (byte_end_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s   = ST_SHIFT;
          cfg_en_nxt_s  = 1'b1;
          cfg_out_nxt_s = shreg_r[BYTE_W-1];
          shreg_nxt_s   = {shreg_r[BYTE_W-2:0], 1'b0};
        end
      end
      ST_CHECK: begin
        if (hs_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CHECK;
        end
      end
      ST_DONE: begin
        if (start_ok_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        shreg_nxt_s = '0;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      shreg_r   <= '0;
      bit_cnt_r <= '0;
      cfg_en_r  <= 1'b0;
      cfg_out_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      shreg_r   <= shreg_nxt_s;
      cfg_en_r  <= cfg_en_nxt_s;
      cfg_out_r <= cfg_out_nxt_s;
      busy_r    <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_SHIFT) ||
                   (state_nxt_s == ST_CHECK);
      done_r    <= (state_nxt_s == ST_DONE);
      if (start_ok_s) begin
        bit_cnt_r <= '0;
      end else if (cfg_en_r && (bit_cnt_r != FULL_CNT)) begin
        bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
    end
  end

`ifdef PAL_CFG_CRC_EN
  logic [7:0] crc_s;
  logic       err_r;

  pal_cfg_crc8 u_crc (
    .clk (clk),
    .rst (rst),
    .en  (cfg_en_r),
    .clr (start_ok_s),
    .din (cfg_out_r),
    .crc (crc_s)
  );

  // Error flag: set on a mismatching CRC byte, cleared by an accepted START
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (start_ok_s) begin
      err_r <= 1'b0;
    end else if ((state_r == ST_CHECK) && hs_s) begin
      err_r <= (bus.din != crc_s);
    end else begin
      err_r <= err_r;
    end
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.din_ready = din_ready_s;
  assign bus.cfg_en    = cfg_en_r;
  assign bus.cfg_out   = cfg_out_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Directed bench for pal_cfg_loader: 192-bit and 12-bit instances, optional PAL_CFG_CRC_EN.
module tb_pal_cfg_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pal_cfg_if bus();
  pal_cfg_if bus12();

  pal_cfg_loader #(.CFG_BITS(192)) dut   (.clk(clk), .rst(rst), .bus(bus));
  pal_cfg_loader #(.CFG_BITS(12))  dut12 (.clk(clk), .rst(rst), .bus(bus12));

`ifdef PAL_CFG_CRC_EN
  localparam int CRC_EXTRA = 1;
`else
  localparam int CRC_EXTRA = 0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit cap_q[$];
  bit cap12_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.cfg_en)   cap_q.push_back(bus.cfg_out);
    if (bus12.cfg_en) cap12_q.push_back(bus12.cfg_out);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(inout int c, input int s1, input int s2);
    bus.start = (c == s1) || (c == s2);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    c++;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Feed nbytes copies of b; gap idle cycles in LOAD before each byte; START at s1/s2
  task automatic send(input logic [7:0] b, input int nbytes, input int gap,
                      input int s1, input int s2);
    int c;
    c = 0;
    for (int k = 0; k < nbytes; k++) begin
      while (!bus.din_ready && c < 4000) step(c, s1, s2);
      chk("ready", 32'(bus.din_ready), 32'd1);
      for (int g = 0; g < gap; g++) begin
        step(c, s1, s2);
        chk("gap_en", 32'(bus.cfg_en), 32'd0);
      end
      bus.din       = b;
      bus.din_valid = 1'b1;
      step(c, s1, s2);
      bus.din_valid = 1'b0;
    end
  endtask

`ifdef PAL_CFG_CRC_EN
  function automatic logic [7:0] crc_pattern(input logic [7:0] b, input int n);
    logic [7:0] crc;
    logic       fb;
    crc = 8'h00;
    for (int i = 0; i < n; i++) begin
      fb  = crc[7] ^ b[7 - (i % 8)];
      crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return crc;
  endfunction

  task automatic send_crc(input logic [7:0] c);
    int n;
    n = 0;
    while (!bus.din_ready && n < 50) begin tick(); n++; end
    chk("crc_ready", 32'(bus.din_ready), 32'd1);
    chk("crc_cfg_en", 32'(bus.cfg_en), 32'd0);
    chk("crc_busy", 32'(bus.busy), 32'd1);
    bus.din       = c;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
  endtask
`endif

  task automatic finish_load(input logic [7:0] b, input int n);
`ifdef PAL_CFG_CRC_EN
    send_crc(crc_pattern(b, n));
`endif
    for (int i = 0; i < 600 && !bus.done; i++) tick();
    chk("done_seen", 32'(bus.done), 32'd1);
  endtask

  task automatic chk_stream(input string tag, input int base, input logic [7:0] b, input int n);
    int mism;
    mism = 0;
    chk({tag, "_pulses"}, 32'(cap_q.size() - base), 32'(n));
    for (int i = 0; i < n && base + i < cap_q.size(); i++)
      if (cap_q[base + i] !== b[7 - (i % 8)]) mism++;
    chk({tag, "_bits"}, 32'(mism), 32'd0);
  endtask

  initial begin
    int c0, base, n;
    logic [11:0] exp12;

    rst = 1'b1;
    bus.start = 1'b0;   bus.din = 8'h00;   bus.din_valid = 1'b0;
    bus12.start = 1'b0; bus12.din = 8'h00; bus12.din_valid = 1'b0;
    repeat (3) tick();
    chk("rst_cfg_en", 32'(bus.cfg_en), 32'd0);
    chk("rst_cfg_out", 32'(bus.cfg_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_ready", 32'(bus.din_ready), 32'd0);
    rst = 1'b0;
    tick();

    // 1: 24 x A5, no gaps, 216 cycles to DONE
    pulse_start();
    c0 = cyc; base = cap_q.size();
    chk("s1_busy", 32'(bus.busy), 32'd1);
    chk("s1_done0", 32'(bus.done), 32'd0);
    send(8'hA5, 24, 0, -1, -1);
    finish_load(8'hA5, 192);
    chk("s1_cycles", 32'(cyc - c0), 32'(216 + CRC_EXTRA));
    chk_stream("s1", base, 8'hA5, 192);
    chk("s1_busy_end", 32'(bus.busy), 32'd0);
    chk("s1_ready_end", 32'(bus.din_ready), 32'd0);
    chk("s1_err", 32'(bus.err), 32'd0);
    repeat (3) tick();
    chk("s1_done_held", 32'(bus.done), 32'd1);

    // 2: same stream with 5 idle cycles before each byte
    pulse_start();
    c0 = cyc; base = cap_q.size();
    chk("s2_done_clr", 32'(bus.done), 32'd0);
    send(8'hA5, 24, 5, -1, -1);
    finish_load(8'hA5, 192);
    chk("s2_cycles", 32'(cyc - c0), 32'(336 + CRC_EXTRA));
    chk_stream("s2", base, 8'hA5, 192);

    // 3: 12-bit instance, F0 then C3, low nibble of C3 dropped
    exp12 = 12'b1111_0000_1100;
    bus12.start = 1'b1; tick(); bus12.start = 1'b0;
    c0 = cyc;
    bus12.din = 8'hF0; bus12.din_valid = 1'b1; tick(); bus12.din_valid = 1'b0;
    n = 0;
    while (!bus12.din_ready && n < 20) begin tick(); n++; end
    chk("s3_ready2", 32'(bus12.din_ready), 32'd1);
    bus12.din = 8'hC3; bus12.din_valid = 1'b1; tick(); bus12.din_valid = 1'b0;
`ifdef PAL_CFG_CRC_EN
    n = 0;
    while (!bus12.din_ready && n < 20) begin tick(); n++; end
    bus12.din = 8'h00;
    for (int i = 0; i < 12; i++)
      bus12.din = {bus12.din[6:0], 1'b0} ^ ((bus12.din[7] ^ exp12[11 - i]) ? 8'h07 : 8'h00);
    bus12.din_valid = 1'b1; tick(); bus12.din_valid = 1'b0;
`endif
    n = 0;
    while (!bus12.done && n < 20) begin tick(); n++; end
    chk("s3_done", 32'(bus12.done), 32'd1);
    chk("s3_cycles", 32'(cyc - c0), 32'(14 + CRC_EXTRA));
    chk("s3_pulses", 32'(cap12_q.size()), 32'd12);
    n = 0;
    for (int i = 0; i < 12 && i < cap12_q.size(); i++)
      if (cap12_q[i] !== exp12[11 - i]) n++;
    chk("s3_bits", 32'(n), 32'd0);
    chk("s3_err", 32'(bus12.err), 32'd0);

    // 4: reset after 50 bits, then full reload
    pulse_start();
    base = cap_q.size();
    send(8'hA5, 7, 0, -1, -1);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("s4_rst_en", 32'(bus.cfg_en), 32'd0);
    tick(); tick();
    chk("s4_bits50", 32'(cap_q.size() - base), 32'd50);
    chk("s4_rst_busy", 32'(bus.busy), 32'd0);
    chk("s4_rst_done", 32'(bus.done), 32'd0);
    chk("s4_rst_ready", 32'(bus.din_ready), 32'd0);
    chk("s4_rst_out", 32'(bus.cfg_out), 32'd0);
    rst = 1'b0;
    tick();
    chk("s4_idle_busy", 32'(bus.busy), 32'd0);
    pulse_start();
    base = cap_q.size();
    send(8'hA5, 24, 0, -1, -1);
    finish_load(8'hA5, 192);
    chk_stream("s4", base, 8'hA5, 192);

    // 5: START at cycles 10 and 40 of a load is ignored
    pulse_start();
    c0 = cyc; base = cap_q.size();
    send(8'hA5, 24, 0, 10, 40);
    finish_load(8'hA5, 192);
    chk("s5_cycles", 32'(cyc - c0), 32'(216 + CRC_EXTRA));
    chk_stream("s5", base, 8'hA5, 192);

`ifdef PAL_CFG_CRC_EN
    // 6: CRC good then bad, START clears
    pulse_start();
    send(8'h00, 24, 0, -1, -1);
    send_crc(8'h00);
    chk("s6_done_ok", 32'(bus.done), 32'd1);
    chk("s6_err_ok", 32'(bus.err), 32'd0);
    pulse_start();
    send(8'h00, 24, 0, -1, -1);
    send_crc(8'h01);
    chk("s6_done_bad", 32'(bus.done), 32'd1);
    chk("s6_err_bad", 32'(bus.err), 32'd1);
`else
    chk("s6_err_tied", 32'(bus.err), 32'd0);
`endif
    pulse_start();
    chk("end_done_clr", 32'(bus.done), 32'd0);
    chk("end_err_clr", 32'(bus.err), 32'd0);
    chk("end_busy", 32'(bus.busy), 32'd1);
    chk("end_ready", 32'(bus.din_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
